// File: rtl/mlp_pkg.sv
// mlp_pkg
//   Shared definitions for the MLP datapath blocks: default operand, result
//   and address widths, the default MAC pipeline latency, and the
//   mac_sequencer FSM state encoding.
package mlp_pkg;

  localparam int unsigned A_WIDTH_DEF     = 8;
  localparam int unsigned B_WIDTH_DEF     = 8;
  localparam int unsigned R_WIDTH_DEF     = 32;
  localparam int unsigned ADDR_WIDTH_DEF  = 8;
  localparam int unsigned MAC_LATENCY_DEF = 1;

  // IDLE   : waiting for a command; the only state that accepts one
  // FETCH  : one operand-memory read per cycle
  // DRAIN  : last operands are in the MAC pipeline, waiting for the result
  // OUTPUT : result is held on the output stream until the consumer takes it
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    DRAIN  = 2'd2,
    OUTPUT = 2'd3
  } seq_state_e;

endpackage

// File: rtl/mac_sequencer_if.sv
// mac_sequencer_if
//   Bundles every non-clock/reset signal of mac_sequencer.
//   master : the sequencer view (takes commands, drives memory reads, MAC
//            controls and the result stream).
//   slave  : the surrounding view (command source, operand memories, MAC,
//            result consumer).
//   Signals:
//     cmd_valid/cmd_ready, cmd_len, cmd_a_base, cmd_b_base : command channel
//     rd_en, a_rd_addr, b_rd_addr, a_rd_data, b_rd_data   : operand memories
//     mac_start, mac_valid, mac_a, mac_b, mac_result       : MAC block
//     out_valid/out_ready, out_data                        : result stream
interface mac_sequencer_if
  import mlp_pkg::*;
#(
  parameter int unsigned A_WIDTH    = A_WIDTH_DEF,
  parameter int unsigned B_WIDTH    = B_WIDTH_DEF,
  parameter int unsigned R_WIDTH    = R_WIDTH_DEF,
  parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF
);

  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [ADDR_WIDTH:0]   cmd_len;
  logic [ADDR_WIDTH-1:0] cmd_a_base;
  logic [ADDR_WIDTH-1:0] cmd_b_base;

  logic                  rd_en;
  logic [ADDR_WIDTH-1:0] a_rd_addr;
  logic [ADDR_WIDTH-1:0] b_rd_addr;
  logic [A_WIDTH-1:0]    a_rd_data;
  logic [B_WIDTH-1:0]    b_rd_data;

  logic                  mac_start;
  logic                  mac_valid;
  logic [A_WIDTH-1:0]    mac_a;
  logic [B_WIDTH-1:0]    mac_b;
  logic [R_WIDTH-1:0]    mac_result;

  logic                  out_valid;
  logic                  out_ready;
  logic [R_WIDTH-1:0]    out_data;

  modport master (
    input  cmd_valid, cmd_len, cmd_a_base, cmd_b_base,
    input  a_rd_data, b_rd_data, mac_result, out_ready,
    output cmd_ready, rd_en, a_rd_addr, b_rd_addr,
    output mac_start, mac_valid, mac_a, mac_b, out_valid, out_data
  );

  modport slave (
    output cmd_valid, cmd_len, cmd_a_base, cmd_b_base,
    output a_rd_data, b_rd_data, mac_result, out_ready,
    input  cmd_ready, rd_en, a_rd_addr, b_rd_addr,
    input  mac_start, mac_valid, mac_a, mac_b, out_valid, out_data
  );

endinterface

// File: rtl/mac_sequencer.sv
// mac_sequencer
//   Runs one dot product per command: reads N operand pairs from two
//   memories (1-cycle read latency), streams them into an external MAC
//   (first pair flagged with mac_start, the rest with mac_valid), waits for
//   the MAC pipeline to settle, and returns the accumulated result on a
//   valid/ready stream.
//   Ports:
//     clk  : clock
//     rst  : synchronous active-high reset
//     bus  : mac_sequencer_if.master (command, memory, MAC and result signals)
module mac_sequencer
  import mlp_pkg::*;
#(
  parameter int unsigned A_WIDTH     = A_WIDTH_DEF,
  parameter int unsigned B_WIDTH     = B_WIDTH_DEF,
  parameter int unsigned R_WIDTH     = R_WIDTH_DEF,
  parameter int unsigned ADDR_WIDTH  = ADDR_WIDTH_DEF,
  parameter int unsigned MAC_LATENCY = MAC_LATENCY_DEF
) (
  input logic             clk,
  input logic             rst,
  mac_sequencer_if.master bus
);

  localparam int unsigned LEN_W   = ADDR_WIDTH + 1;
  localparam int unsigned WAIT_W  = $clog2(MAC_LATENCY + 1) + 1;
  localparam logic [LEN_W-1:0]  MAX_LEN   = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAC_LATENCY);

  seq_state_e            state_q, state_d;
  logic [ADDR_WIDTH-1:0] a_addr_q, a_addr_d;
  logic [ADDR_WIDTH-1:0] b_addr_q, b_addr_d;
  logic [LEN_W-1:0]      remaining_q, remaining_d;  // reads still to issue
  logic                  first_q, first_d;          // next read is element 0
  logic                  rd_vld_q, rd_vld_d;        // memory data returns now
  logic                  rd_first_q, rd_first_d;    // ...and it is element 0
  logic [WAIT_W-1:0]     wait_q, wait_d;            // cycles since last operand
  logic [R_WIDTH-1:0]    out_data_q, out_data_d;

  logic [LEN_W-1:0]      len_clamped;
  logic                  rd_en;
  logic [A_WIDTH-1:0]    mac_a;
  logic [B_WIDTH-1:0]    mac_b;

  // A full address space is the longest meaningful dot product.
  assign len_clamped = (bus.cmd_len > MAX_LEN) ? MAX_LEN : bus.cmd_len;

  assign rd_en = (state_q == FETCH);

  always_comb begin
    // NOTE: every signal written here gets a default first so no path
    // leaves it unassigned; otherwise synthesis infers a latch.
    state_d     = state_q;
    a_addr_d    = a_addr_q;
    b_addr_d    = b_addr_q;
    remaining_d = remaining_q;
    first_d     = first_q;
    wait_d      = wait_q;
    out_data_d  = out_data_q;
    rd_vld_d    = rd_en;
    rd_first_d  = rd_en && first_q;

    unique case (state_q)
      IDLE: begin
        if (bus.cmd_valid) begin
          if (len_clamped == '0) begin
            // Empty dot product: answer 0 without touching the memories.
            out_data_d = '0;
            state_d    = OUTPUT;
          end else begin
            a_addr_d    = bus.cmd_a_base;
            b_addr_d    = bus.cmd_b_base;
            remaining_d = len_clamped;
            first_d     = 1'b1;
            state_d     = FETCH;
          end
        end
      end

      FETCH: begin
        // Address arithmetic wraps modulo 2^ADDR_WIDTH by its width alone.
        a_addr_d    = a_addr_q + ADDR_WIDTH'(1);
        b_addr_d    = b_addr_q + ADDR_WIDTH'(1);
        remaining_d = remaining_q - LEN_W'(1);
        first_d     = 1'b0;
        if (remaining_q == LEN_W'(1)) begin
          // First DRAIN cycle is the cycle the last operands reach the MAC.
          wait_d  = '0;
          state_d = DRAIN;
        end
      end

      DRAIN: begin
        if (wait_q == WAIT_LAST) begin
          out_data_d = bus.mac_result;
          state_d    = OUTPUT;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end

      OUTPUT: begin
        if (bus.out_ready) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state is updated with non-blocking assignments so every
  // flop samples the values from before this edge, independent of order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      a_addr_q    <= '0;
      b_addr_q    <= '0;
      remaining_q <= '0;
      first_q     <= 1'b0;
      rd_vld_q    <= 1'b0;
      rd_first_q  <= 1'b0;
      wait_q      <= '0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      a_addr_q    <= a_addr_d;
      b_addr_q    <= b_addr_d;
      remaining_q <= remaining_d;
      first_q     <= first_d;
      rd_vld_q    <= rd_vld_d;
      rd_first_q  <= rd_first_d;
      wait_q      <= wait_d;
      out_data_q  <= out_data_d;
    end
  end

  // Operands are forwarded only while read data is returning; rd_vld_q is
  // cleared by reset, so reads in flight across a reset are dropped.
  assign mac_a = rd_vld_q ? bus.a_rd_data : '0;
  assign mac_b = rd_vld_q ? bus.b_rd_data : '0;

  assign bus.cmd_ready = (state_q == IDLE);
  assign bus.rd_en     = rd_en;
  assign bus.a_rd_addr = a_addr_q;
  assign bus.b_rd_addr = b_addr_q;
  assign bus.mac_start = rd_vld_q && rd_first_q;
  assign bus.mac_valid = rd_vld_q && !rd_first_q;
  assign bus.mac_a     = mac_a;
  assign bus.mac_b     = mac_b;
  assign bus.out_valid = (state_q == OUTPUT);
  assign bus.out_data  = out_data_q;

endmodule

// File: tb/tb_mac_sequencer.sv
module tb_mac_sequencer;
  import mlp_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mac_sequencer_if bus ();

  mac_sequencer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Operand memories with 1-cycle read latency.
  logic signed [7:0] mem_a [256];
  logic signed [7:0] mem_b [256];

  always @(posedge clk) begin
    if (bus.rd_en) begin
      bus.a_rd_data <= mem_a[bus.a_rd_addr];
      bus.b_rd_data <= mem_b[bus.b_rd_addr];
    end
  end

  // Reference MAC, latency 1: start loads a*b, valid accumulates a*b.
  logic signed [31:0] acc;
  logic signed [15:0] prod;
  assign prod = $signed(bus.mac_a) * $signed(bus.mac_b);
  always @(posedge clk) begin
    if (rst)                acc <= '0;
    else if (bus.mac_start) acc <= {{16{prod[15]}}, prod};
    else if (bus.mac_valid) acc <= acc + {{16{prod[15]}}, prod};
  end
  assign bus.mac_result = acc;

  // Activity monitor, sampled mid-cycle.
  int rd_cnt = 0, start_cnt = 0, valid_cnt = 0, both_cnt = 0;
  int a_log[$];
  int b_log[$];
  always @(negedge clk) begin
    if (bus.rd_en) begin
      rd_cnt++;
      a_log.push_back(int'(bus.a_rd_addr));
      b_log.push_back(int'(bus.b_rd_addr));
    end
    if (bus.mac_start) start_cnt++;
    if (bus.mac_valid) valid_cnt++;
    if (bus.mac_start && bus.mac_valid) both_cnt++;
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_cmd_ready"}, bus.cmd_ready, 1);
    check({tag, "_rd_en"},     bus.rd_en,     0);
    check({tag, "_a_addr"},    bus.a_rd_addr, 0);
    check({tag, "_b_addr"},    bus.b_rd_addr, 0);
    check({tag, "_mac_start"}, bus.mac_start, 0);
    check({tag, "_mac_valid"}, bus.mac_valid, 0);
    check({tag, "_mac_a"},     bus.mac_a,     0);
    check({tag, "_mac_b"},     bus.mac_b,     0);
    check({tag, "_out_valid"}, bus.out_valid, 0);
    check({tag, "_out_data"},  bus.out_data,  0);
  endtask

  // Issue one command, wait for the result, optionally stall the consumer
  // for 'hold' cycles, then complete the handshake.
  task automatic run_cmd(input string tag, input int len, input int a_base,
                         input int b_base, input int hold,
                         input longint exp_data, input int exp_lat,
                         input int exp_rd);
    int r0, s0, v0, k;
    bit stable, busy_ok;
    r0 = rd_cnt; s0 = start_cnt; v0 = valid_cnt;
    a_log.delete();
    b_log.delete();
    bus.out_ready  = (hold == 0);
    bus.cmd_valid  = 1'b1;
    bus.cmd_len    = 9'(len);
    bus.cmd_a_base = 8'(a_base);
    bus.cmd_b_base = 8'(b_base);
    tick();
    bus.cmd_valid = 1'b0;
    k = 1;
    while (!bus.out_valid && k < 2000) begin
      tick();
      k++;
    end
    check({tag, "_latency"}, k, exp_lat);
    check({tag, "_out_data"}, bus.out_data, exp_data);
    if (hold > 0) begin
      stable  = 1'b1;
      busy_ok = 1'b1;
      repeat (hold) begin
        if (!bus.out_valid || bus.out_data !== 32'(exp_data)) stable = 1'b0;
        if (bus.cmd_ready !== 1'b0) busy_ok = 1'b0;
        tick();
      end
      check({tag, "_held_stable"}, stable, 1);
      check({tag, "_cmd_ready_low"}, busy_ok, 1);
    end
    bus.out_ready = 1'b1;
    tick();
    check({tag, "_out_valid_drop"}, bus.out_valid, 0);
    check({tag, "_idle_ready"}, bus.cmd_ready, 1);
    check({tag, "_rd_count"}, rd_cnt - r0, exp_rd);
    check({tag, "_start_count"}, start_cnt - s0, (exp_rd > 0) ? 1 : 0);
    check({tag, "_valid_count"}, valid_cnt - v0, (exp_rd > 0) ? exp_rd - 1 : 0);
  endtask

  initial begin
    int s1, v1;
    for (int i = 0; i < 256; i++) begin
      mem_a[i] = '0;
      mem_b[i] = '0;
    end
    mem_a[0] = 8'sd3;   mem_a[1] = -8'sd1;  mem_a[2] = 8'sd4;   mem_a[3] = 8'sd1;
    mem_b[0] = 8'sd2;   mem_b[1] = 8'sd5;   mem_b[2] = -8'sd2;  mem_b[3] = 8'sd10;
    mem_a[16] = -8'sd128;
    mem_b[16] = -8'sd128;
    mem_a[254] = 8'sd5; mem_a[255] = 8'sd2;
    for (int i = 100; i < 104; i++) mem_b[i] = 8'sd1;

    bus.cmd_valid  = 1'b0;
    bus.cmd_len    = '0;
    bus.cmd_a_base = '0;
    bus.cmd_b_base = '0;
    bus.out_ready  = 1'b1;
    rst = 1'b1;
    tick();
    tick();
    check_reset_outputs("reset");
    rst = 1'b0;
    tick();

    // 3*2 - 1*5 + 4*(-2) + 1*10 = 3
    run_cmd("n4", 4, 0, 0, 0, 3, 7, 4);
    // (-128)*(-128) = 16384
    run_cmd("n1", 1, 16, 16, 0, 16384, 4, 1);
    // Empty command: result 0 on the next cycle
    run_cmd("n0", 0, 5, 5, 0, 0, 1, 0);
    // Consumer stalls 5 cycles
    run_cmd("hold", 4, 0, 0, 5, 3, 7, 4);

    // Reset during the 3rd FETCH cycle of an N=8 command
    bus.cmd_valid  = 1'b1;
    bus.cmd_len    = 9'd8;
    bus.cmd_a_base = 8'd0;
    bus.cmd_b_base = 8'd0;
    tick();
    bus.cmd_valid = 1'b0;
    tick();
    tick();
    check("midrst_fetching", bus.rd_en, 1);
    rst = 1'b1;
    tick();
    check_reset_outputs("midrst");
    rst = 1'b0;
    s1 = start_cnt;
    v1 = valid_cnt;
    repeat (3) tick();
    check("midrst_no_start", start_cnt - s1, 0);
    check("midrst_no_valid", valid_cnt - v1, 0);
    run_cmd("after_rst", 4, 0, 0, 0, 3, 7, 4);

    // Wrapping addresses: A 254,255,0,1 = 5,2,3,-1; B all 1 -> 9
    run_cmd("wrap", 4, 254, 100, 0, 9, 7, 4);
    check("wrap_a_addr0", a_log[0], 254);
    check("wrap_a_addr1", a_log[1], 255);
    check("wrap_a_addr2", a_log[2], 0);
    check("wrap_a_addr3", a_log[3], 1);
    check("wrap_b_addr0", b_log[0], 100);
    check("wrap_b_addr3", b_log[3], 103);
    // Back-to-back with the previous command
    run_cmd("b2b", 4, 0, 0, 0, 3, 7, 4);

    // Length 511 clamps to 256: 3 (elements 0..3) + 16384 (element 16)
    run_cmd("clamp", 511, 0, 0, 0, 16387, 259, 256);

    check("no_start_valid_overlap", both_cnt, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mac_sequencer.md
MAC_SEQUENCER -- requirements
Module: mac_sequencer

Interface
REQ-001 SHALL have parameter A_WIDTH, default 8, meaning operand A width (signed).
REQ-002 SHALL have parameter B_WIDTH, default 8, meaning operand B width (signed).
REQ-003 SHALL have parameter R_WIDTH, default 32, meaning MAC result width.
REQ-004 SHALL have parameter ADDR_WIDTH, default 8, meaning operand memory address width.
REQ-005 SHALL have parameter MAC_LATENCY, default 1, meaning cycles from last operand cycle to a valid mac_result.
REQ-006 SHALL use one clock and a synchronous, active-high reset, with ports: clk  in  1  clock; rst  in  1  synchronous active-high reset.
REQ-007 cmd_valid  in  1  command request; cmd_ready  out  1  block accepts command.
REQ-008 cmd_len  in  ADDR_WIDTH+1  dot-product length N; cmd_a_base, cmd_b_base  in  ADDR_WIDTH  base addresses.
REQ-009 rd_en  out  1  read strobe to both operand memories; a_rd_addr, b_rd_addr  out  ADDR_WIDTH  read addresses.
REQ-010 a_rd_data  in  A_WIDTH; b_rd_data  in  B_WIDTH  memory data, valid exactly 1 cycle after rd_en.
REQ-011 mac_start, mac_valid  out  1  MAC controls; mac_a  out  A_WIDTH; mac_b  out  B_WIDTH  MAC operands.
REQ-012 mac_result  in  R_WIDTH  accumulator value from the mac block.
REQ-013 out_valid  out  1; out_ready  in  1; out_data  out  R_WIDTH  result stream (valid/ready).

Function
REQ-014 SHALL implement FSM states IDLE, FETCH, DRAIN, OUTPUT.
REQ-015 cmd_ready SHALL be 1 only in IDLE; command accepted when cmd_valid && cmd_ready; IDLE->FETCH on accept with N>0, IDLE->OUTPUT with out_data=0 on accept with N=0.
REQ-016 In FETCH, rd_en SHALL be 1 for exactly N consecutive cycles starting the cycle after accept; addresses base+0..base+N-1, wrapping modulo 2^ADDR_WIDTH.
REQ-017 Element 0 SHALL be presented with mac_start=1, mac_valid=0 in the cycle its data returns; elements 1..N-1 with mac_start=0, mac_valid=1 in consecutive cycles; mac_a/mac_b SHALL equal a_rd_data/b_rd_data in those cycles.
REQ-018 mac_start and mac_valid SHALL never be 1 simultaneously and SHALL be 0 outside the operand window.
REQ-019 FETCH->DRAIN after last rd_en; DRAIN SHALL wait until MAC_LATENCY cycles after the last operand cycle, then capture mac_result into out_data and enter OUTPUT.
REQ-020 In OUTPUT, out_valid SHALL be 1 and out_data stable until out_ready=1; on that handshake cycle out_valid drops next cycle and FSM returns to IDLE.
REQ-021 Total latency for N>0 with out_ready=1: out_valid first high N+MAC_LATENCY+2 cycles after the accept cycle.
REQ-022 cmd_len values above 2^ADDR_WIDTH SHALL be clamped to 2^ADDR_WIDTH.
REQ-023 cmd_valid while not IDLE SHALL be ignored (no buffering).

Reset
REQ-024 On rst=1 at a clk edge, FSM SHALL enter IDLE from any state, including mid-FETCH/DRAIN/OUTPUT.
REQ-025 Reset values: cmd_ready=1 (first cycle after reset), rd_en=0, addresses=0, mac_start=0, mac_valid=0, mac_a=0, mac_b=0, out_valid=0, out_data=0.
REQ-026 Memory data returning after reset SHALL NOT produce mac_start/mac_valid.

Structure
REQ-027 Width defaults and the FSM state encoding SHALL live in shared package mlp_pkg.
REQ-028 Block SHALL be a single module, no sub-modules; mac is instantiated alongside it by the parent.

Verification
REQ-029 N=4, A=[3,-1,4,1], B=[2,5,-2,10], bench mac model -> one mac_start then 3 mac_valid, out_data=3.
REQ-030 N=1, A=[-128], B=[-128] -> mac_start only, mac_valid never, out_data=16384.
REQ-031 N=0 -> no rd_en, no mac_start/mac_valid, out_valid next cycle with out_data=0.
REQ-032 N=4 with out_ready low 5 cycles -> out_data=3 held stable all 5 cycles, cmd_ready=0 until handshake.
REQ-033 rst pulsed during 3rd FETCH cycle of N=8 -> all outputs at reset values next cycle; following N=4 command yields 3.
REQ-034 cmd_a_base=254, N=4 -> addresses 254,255,0,1; two back-to-back commands each produce correct result.
